trig_capture_ctrl: RTL and testbench
====================================

Name: trig_capture_ctrl

Overview:
- Consumer side of the trigger-match interface: takes the matcher's tri_succeed / tri_data / tri_data_vld stream and captures a pre/post-trigger window into an internal circular buffer.
- After capture completes, replays the window in chronological order over a valid/ready stream to the debug readout path.
- Sits between the trigger matcher and the capture readout logic in the debug subsystem.

Parameters:
DATA_WIDTH, 32, sample width (equals the matcher's data width)
ADDR_W, 8, buffer address width; DEPTH = 2**ADDR_W entries

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high (asserted when rst_n = 1)
arm  in  1  single-cycle pulse: start a capture; accepted only in IDLE or DONE
abort  in  1  synchronous clear to IDLE from any state; wins over every other input
cfg_pre_len  in  ADDR_W  number of samples kept before the trigger
cfg_post_len  in  ADDR_W+1  number of samples kept from the trigger onward
tri_succeed  in  1  trigger pulse from the matcher
tri_data  in  DATA_WIDTH  sample from the matcher
tri_data_vld  in  1  tri_data valid
out_data  out  DATA_WIDTH  replayed sample
out_vld  out  1  out_data valid
out_rdy  in  1  downstream ready
out_last  out  1  marks the final sample of the window, qualified by out_vld
cap_busy  out  1  high in PRE, ARMED and POST
cap_done  out  1  high in DONE and READ
cap_state  out  3  IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4, READ=5

Behaviour:
- Reset values: all outputs 0, state IDLE, all pointers and counters 0. Buffer contents are not reset.
- On an accepted arm, latch configuration:
  - pre_q = cfg_pre_len
  - post_q = min(cfg_post_len, DEPTH - pre_q), so pre_q + post_q <= DEPTH
  - wr_ptr = 0, fill = 0; next state PRE.
- Writing: in PRE, ARMED and POST, every tri_data_vld writes mem[wr_ptr] and increments wr_ptr modulo DEPTH (wraps silently). No writes in any other state.
- PRE:
  - fill counts written samples, saturating at DEPTH.
  - Go to ARMED when fill (including this cycle's write) >= pre_q; pre_q = 0 goes to ARMED on the cycle after arm.
  - tri_succeed in PRE is ignored.
- ARMED, on tri_succeed:
  - start_ptr = wr_ptr - pre_q (mod DEPTH), using wr_ptr before any same-cycle write.
  - post_cnt = tri_data_vld ? 1 : 0, i.e. a sample arriving with the trigger is the first post sample.
  - Next state is POST, or DONE directly if post_q == 0 or post_cnt already equals post_q.
- POST:
  - Each valid sample increments post_cnt; go to DONE in the cycle post_cnt reaches post_q.
  - tri_succeed in POST is ignored.
- DONE:
  - Next cycle enter READ with rd_ptr = start_ptr, rd_cnt = pre_q + post_q.
  - If the total is 0, go to IDLE instead.
  - arm in DONE starts a new capture and discards the pending window.
- READ:
  - out_data is registered; out_vld is asserted no later than 2 cycles after entering READ.
  - While out_vld && !out_rdy, out_data / out_vld / out_last hold stable.
  - Each handshake advances rd_ptr modulo DEPTH.
  - out_last is high on the rd_cnt-th sample; its handshake returns to IDLE next cycle with out_vld = 0.
  - arm is ignored in READ.
- abort or reset mid-operation:
  - Return to IDLE and clear all outputs the next cycle (reset: immediately).
  - The in-flight window is lost; no out_last is emitted.
- arm and abort in the same cycle: abort wins; stay in IDLE.
- Throughput: one sample written per cycle in capture states, one sample transferred per cycle in READ when out_rdy is held high.

Test Plan:
1. pre=4, post=4; tri_data_vld every cycle with values 0x100, 0x101, ...; tri_succeed coincident with 0x10A -> ARMED after 0x103; stream out 0x106..0x10D, out_last on 0x10D; cap_state returns to 0.
2. pre=0, post=3; trigger with sample 0x20 -> ARMED the cycle after arm; stream out 0x20, 0x21, 0x22.
3. pre=8; tri_succeed pulses while fill < 8 -> stays in PRE; the first trigger after ARMED defines the window, exactly 8 pre samples.
4. DEPTH=256, pre=250, post=20 -> post clamped to 6; 256 samples read out, covering the wrap, in chronological order.
5. Test 1 stimulus with out_rdy toggling 1,0,0,1 randomly -> out_data stable while stalled; no sample lost or duplicated.
6. abort asserted in POST, and separately rst_n pulsed high in READ -> state 0, out_vld = 0, cap_done = 0; a fresh arm then completes correctly.

Source files
------------

// File: rtl/trig_capture_ctrl.sv
// Trigger capture controller: records a pre/post-trigger window of matcher
// samples into a circular buffer, then replays it over a valid/ready stream.
//   clk, rst_n (async, active-high), arm/abort control, cfg_pre/post_len,
//   tri_* matcher stream in, out_* readout stream, cap_* status out.
module trig_capture_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     cfg_pre_len,
  input  logic [ADDR_W:0]       cfg_post_len,
  input  logic                  tri_succeed,
  input  logic [DATA_WIDTH-1:0] tri_data,
  input  logic                  tri_data_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  out_last,
  output logic                  cap_busy,
  output logic                  cap_done,
  output logic [2:0]            cap_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4,
    S_READ  = 3'd5
  } state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     pre_q, pre_d;
  logic [ADDR_W:0]       post_q, post_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       fill_q, fill_d;
  logic [ADDR_W:0]       post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0]     start_ptr_q, start_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       rd_cnt_q, rd_cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_vld_q, out_vld_d;
  logic                  out_last_q, out_last_d;

  logic            cap_st;
  logic            wr_en;
  logic            hs;
  logic            arm_go;
  logic [ADDR_W:0] room;
  logic [ADDR_W:0] post_cfg;
  logic [ADDR_W:0] fill_inc;
  logic [ADDR_W:0] total;

  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    post_d      = post_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    post_cnt_d  = post_cnt_q;
    start_ptr_d = start_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_cnt_d    = rd_cnt_q;
    out_data_d  = out_data_q;
    out_vld_d   = out_vld_q;
    out_last_d  = out_last_q;
    arm_go      = 1'b0;

    cap_st = (state_q == S_PRE) || (state_q == S_ARMED)
          || (state_q == S_POST);
    wr_en  = cap_st && tri_data_vld;
    hs     = out_vld_q && out_rdy;

    // clamp post so the whole window fits in the buffer
    room     = DEPTH_W - {1'b0, cfg_pre_len};
    post_cfg = (cfg_post_len < room) ? cfg_post_len : room;
    fill_inc = (tri_data_vld && fill_q != DEPTH_W)
             ? fill_q + ONE_W : fill_q;
    total    = {1'b0, pre_q} + post_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + ONE_A;

    unique case (state_q)
      S_IDLE: begin
        if (arm) arm_go = 1'b1;
      end
      S_PRE: begin
        fill_d = fill_inc;
        if (fill_inc >= {1'b0, pre_q}) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (tri_succeed) begin
          start_ptr_d = wr_ptr_q - pre_q;
          post_cnt_d  = {{ADDR_W{1'b0}}, tri_data_vld};
          if (post_q == '0 || post_cnt_d == post_q)
            state_d = S_DONE;
          else
            state_d = S_POST;
        end
      end
      S_POST: begin
        if (tri_data_vld) begin
          post_cnt_d = post_cnt_q + ONE_W;
          if (post_cnt_d == post_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (arm) begin
          arm_go = 1'b1;
        end else if (total == '0) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_READ;
          rd_ptr_d = start_ptr_q;
          rd_cnt_d = total;
        end
      end
      S_READ: begin
        // rd_cnt counts samples not yet loaded into the output register
        if (hs && out_last_q) begin
          state_d    = S_IDLE;
          out_vld_d  = 1'b0;
          out_last_d = 1'b0;
        end else if ((!out_vld_q || out_rdy) && rd_cnt_q != '0) begin
          out_data_d = mem[rd_ptr_q];
          out_vld_d  = 1'b1;
          out_last_d = (rd_cnt_q == ONE_W);
          rd_ptr_d   = rd_ptr_q + ONE_A;
          rd_cnt_d   = rd_cnt_q - ONE_W;
        end else if (hs) begin
          out_vld_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (arm_go) begin
      state_d    = S_PRE;
      pre_d      = cfg_pre_len;
      post_d     = post_cfg;
      wr_ptr_d   = '0;
      fill_d     = '0;
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end

    if (abort) begin
      state_d    = S_IDLE;
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
      out_data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      post_q      <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      post_cnt_q  <= '0;
      start_ptr_q <= '0;
      rd_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      out_data_q  <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      post_cnt_q  <= post_cnt_d;
      start_ptr_q <= start_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      out_data_q  <= out_data_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= tri_data;
  end

  assign out_data  = out_data_q;
  assign out_vld   = out_vld_q;
  assign out_last  = out_last_q;
  assign cap_busy  = cap_st;
  assign cap_done  = (state_q == S_DONE) || (state_q == S_READ);
  assign cap_state = state_q;

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Scoreboard bench for trig_capture_ctrl: directed captures push expected
// windows; a negedge monitor pops on every out_vld/out_rdy handshake.
module tb_trig_capture_ctrl;

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic        abort;
  logic [7:0]  cfg_pre_len;
  logic [8:0]  cfg_post_len;
  logic        tri_succeed;
  logic [31:0] tri_data;
  logic        tri_data_vld;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_rdy;
  logic        out_last;
  logic        cap_busy;
  logic        cap_done;
  logic [2:0]  cap_state;

  int checks;
  int fails;
  logic [32:0] exp_q[$];
  bit rdy_random;

  trig_capture_ctrl #(.DATA_WIDTH(32), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .cfg_pre_len(cfg_pre_len), .cfg_post_len(cfg_post_len),
    .tri_succeed(tri_succeed), .tri_data(tri_data),
    .tri_data_vld(tri_data_vld), .out_data(out_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last),
    .cap_busy(cap_busy), .cap_done(cap_done), .cap_state(cap_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // ready driver, changes just after each rising edge
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_rdy = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: compare every handshake, and stability while stalled
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [32:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_hold", {31'd0, out_vld, out_last, out_data},
              {31'd0, 1'b1, prev_last, prev_data});
        end
        if (out_vld && out_rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", {32'd0, out_data}, 64'hdead);
          end else begin
            e = exp_q.pop_front();
            chk("out_sample", {31'd0, out_last, out_data},
                {31'd0, e});
          end
        end
        prev_stall = out_vld && !out_rdy;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  task automatic push_range(input logic [31:0] base, input int n);
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      v = base + 32'(i);
      exp_q.push_back({(i == n - 1), v});
    end
  endtask

  // arm, then stream samples; idx counts samples, lead idle cycles first
  task automatic stream(input int pre, input int post,
                        input logic [31:0] base, input int lead,
                        input int n, input int t0, input int t1,
                        input int t2, input int t3,
                        input int armed_cyc, input int abort_c);
    int  idx;
    bit  seen;
    seen = 1'b0;
    @(negedge clk);
    cfg_pre_len  = 8'(pre);
    cfg_post_len = 9'(post);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    for (int c = 1; c <= n; c++) begin
      idx          = c - lead - 1;
      tri_data_vld = (c > lead);
      tri_data     = base + 32'(idx);
      tri_succeed  = (c > lead) &&
                     (idx == t0 || idx == t1 || idx == t2 || idx == t3);
      abort        = (c == abort_c);
      @(negedge clk);
      if (!seen && cap_state == 3'd2) begin
        seen = 1'b1;
        chk("armed_cycle", 64'(c), 64'(armed_cyc));
        chk("armed_busy", {63'd0, cap_busy}, 64'd1);
      end
      if (c == abort_c) begin
        chk("abort_state", {61'd0, cap_state}, 64'd0);
        chk("abort_outs", {61'd0, out_vld, cap_done, cap_busy}, 64'd0);
      end
    end
    if (!seen) chk("armed_seen", 64'd0, 64'd1);
    tri_data_vld = 1'b0;
    tri_succeed  = 1'b0;
    abort        = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || cap_state != 3'd0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_drain"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_idle"}, {60'd0, out_vld, cap_state}, 64'd0);
  endtask

  initial begin
    checks       = 0;
    fails        = 0;
    rdy_random   = 1'b0;
    rst_n        = 1'b1;
    arm          = 1'b0;
    abort        = 1'b0;
    cfg_pre_len  = '0;
    cfg_post_len = '0;
    tri_succeed  = 1'b0;
    tri_data     = '0;
    tri_data_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", {61'd0, cap_state}, 64'd0);
    chk("rst_flags", {60'd0, out_vld, out_last, cap_busy, cap_done}, 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    rst_n = 1'b0;
    @(negedge clk);

    // arm and abort together: abort wins
    arm   = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    arm   = 1'b0;
    abort = 1'b0;
    chk("arm_abort", {61'd0, cap_state}, 64'd0);

    // 1: pre=4 post=4, trigger on 0x10A
    push_range(32'h106, 8);
    stream(4, 4, 32'h100, 0, 16, 10, -1, -1, -1, 4, 0);
    drain("t1");

    // 2: pre=0 post=3, trigger with 0x20
    push_range(32'h20, 3);
    stream(0, 3, 32'h20, 1, 6, 0, -1, -1, -1, 1, 0);
    drain("t2");

    // 3: early triggers ignored in PRE, one more ignored in POST
    push_range(32'h304, 12);
    stream(8, 4, 32'h300, 0, 18, 2, 5, 12, 14, 8, 0);
    drain("t3");

    // 4: post clamped to 6, full 256-entry window wrapping the buffer
    push_range(32'h4032, 256);
    stream(250, 20, 32'h4000, 0, 310, 300, -1, -1, -1, 250, 0);
    drain("t4");

    // 5: test 1 with random backpressure
    rdy_random = 1'b1;
    push_range(32'h506, 8);
    stream(4, 4, 32'h500, 0, 16, 10, -1, -1, -1, 4, 0);
    drain("t5");
    rdy_random = 1'b0;

    // 6a: abort in POST, then a fresh capture
    stream(2, 8, 32'h600, 0, 7, 4, -1, -1, -1, 2, 7);
    repeat (4) @(negedge clk);
    drain("t6a_abort");
    push_range(32'h686, 8);
    stream(4, 4, 32'h680, 0, 16, 10, -1, -1, -1, 4, 0);
    drain("t6a");

    // 6b: reset pulse during READ, then a fresh capture
    push_range(32'h706, 8);
    stream(4, 4, 32'h700, 0, 16, 10, -1, -1, -1, 4, 0);
    begin
      int k;
      k = 0;
      while (exp_q.size() > 5 && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk("t6b_reading", {61'd0, cap_state}, 64'd5);
    end
    rst_n = 1'b1;
    #1;
    chk("t6b_rst_state", {61'd0, cap_state}, 64'd0);
    chk("t6b_rst_outs", {62'd0, out_vld, cap_done}, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    push_range(32'h800, 3);
    stream(0, 3, 32'h800, 1, 6, 0, -1, -1, -1, 1, 0);
    drain("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
